// File: rtl/rr_decoder_arbiter_pkg.sv
// Shared definitions for the round-robin decoded-select arbiter.
// State encoding and requester/index sizing used by the top and its decoder.
package rr_decoder_arbiter_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_decoder_arbiter_decoder.sv
// 3-to-8 select decoder built as a 2-level tree: {b,a} picks one of four lines,
// c steers that group to the upper or lower half, enable gates everything.
module rr_decoder_arbiter_decoder (
  input  logic       en,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  output logic [7:0] y
);

  logic [3:0] lo;

  always_comb begin
    lo = 4'b0001 << {b, a};
    y  = 8'h00;
    if (en) begin
      y = c ? {lo, 4'b0000} : {4'b0000, lo};
    end
  end

endmodule

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter sharing one decoded select among 8 requesters, with a
// forced one-cycle dead gap between owners and an optional hold timeout.
module rr_decoder_arbiter
  import rr_decoder_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic               timeout
);

  // With the timeout disabled the counter simply saturates at all-ones.
  localparam logic [CNT_W-1:0] HOLD_LIMIT =
    (MAX_HOLD == 0) ? {CNT_W{1'b1}} : CNT_W'(MAX_HOLD);

  arb_state_t       state, state_n;
  logic [IDX_W-1:0] idx_q, idx_n;
  logic [IDX_W-1:0] ptr, ptr_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             timeout_q, timeout_n;
  logic [IDX_W-1:0] winner;
  logic             expired;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      idx_q     <= '0;
      ptr       <= '0;
      cnt       <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_n;
      idx_q     <= idx_n;
      ptr       <= ptr_n;
      cnt       <= cnt_n;
      timeout_q <= timeout_n;
    end
  end

  // First set request scanning upward from ptr, wrapping past 7.
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] cand;
    winner = ptr;
    found  = 1'b0;
    cand   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ptr + IDX_W'(i);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign expired = (MAX_HOLD != 0) && (cnt == HOLD_LIMIT);

  always_comb begin
    state_n   = state;
    idx_n     = idx_q;
    ptr_n     = ptr;
    cnt_n     = cnt;
    timeout_n = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req != '0) begin
          state_n = ST_OWNED;
          idx_n   = winner;
          cnt_n   = CNT_W'(1);
        end
      end
      ST_OWNED: begin
        if (done || !req[idx_q] || expired) begin
          state_n   = ST_IDLE;
          ptr_n     = idx_q + IDX_W'(1);
          cnt_n     = '0;
          timeout_n = expired && !done;
        end else if (cnt != HOLD_LIMIT) begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign grant_valid = (state == ST_OWNED);
  assign grant_idx   = idx_q;
  assign timeout     = timeout_q;

  rr_decoder_arbiter_decoder u_decoder_3_to_8 (
    .en (grant_valid),
    .a  (idx_q[0]),
    .b  (idx_q[1]),
    .c  (idx_q[2]),
    .y  (grant_onehot)
  );

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Directed bench for rr_decoder_arbiter built with MAX_HOLD = 4 so the hold
// timeout is reachable in a few cycles; each scenario task checks inline.
module tb_rr_decoder_arbiter;

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic       done;
  logic       grant_valid;
  logic [2:0] grant_idx;
  logic [7:0] grant_onehot;
  logic       timeout;

  int pass_cnt  = 0;
  int check_cnt = 0;

  rr_decoder_arbiter #(.MAX_HOLD(4), .CNT_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .done         (done),
    .grant_valid  (grant_valid),
    .grant_idx    (grant_idx),
    .grant_onehot (grant_onehot),
    .timeout      (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] r, input logic d);
    req  = r;
    done = d;
  endtask

  task automatic do_reset();
    applyStimulus(8'h00, 1'b0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    check_cnt++;
    if (grant_valid !== 1'b0) $display("[TB] FAIL reset_gv got %b want 0", grant_valid);
    else pass_cnt++;
    check_cnt++;
    if (grant_idx !== 3'd0) $display("[TB] FAIL reset_idx got %0d want 0", grant_idx);
    else pass_cnt++;
    check_cnt++;
    if (grant_onehot !== 8'h00) $display("[TB] FAIL reset_onehot got %h want 00", grant_onehot);
    else pass_cnt++;
    check_cnt++;
    if (timeout !== 1'b0) $display("[TB] FAIL reset_timeout got %b want 0", timeout);
    else pass_cnt++;
    // done while idle must not create a grant
    applyStimulus(8'h00, 1'b1);
    tick();
    check_cnt++;
    if (grant_valid !== 1'b0) $display("[TB] FAIL idle_done_gv got %b want 0", grant_valid);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    do_reset();
    applyStimulus(8'b0000_0100, 1'b0);
    tick();
    check_cnt++;
    if ({grant_valid, grant_idx} !== {1'b1, 3'd2})
      $display("[TB] FAIL basic_grant got v=%b idx=%0d want v=1 idx=2", grant_valid, grant_idx);
    else pass_cnt++;
    check_cnt++;
    if (grant_onehot !== 8'h04) $display("[TB] FAIL basic_onehot got %h want 04", grant_onehot);
    else pass_cnt++;
    applyStimulus(8'b0000_0100, 1'b1);
    tick();
    check_cnt++;
    if ({grant_valid, timeout, grant_onehot} !== {1'b0, 1'b0, 8'h00})
      $display("[TB] FAIL basic_release got v=%b to=%b oh=%h want 0 0 00", grant_valid, timeout, grant_onehot);
    else pass_cnt++;
    check_cnt++;
    if (grant_idx !== 3'd2) $display("[TB] FAIL basic_idx_hold got %0d want 2", grant_idx);
    else pass_cnt++;
    // ptr is now 3, so a full request vector must pick 3
    applyStimulus(8'hFF, 1'b0);
    tick();
    check_cnt++;
    if ({grant_valid, grant_idx} !== {1'b1, 3'd3})
      $display("[TB] FAIL basic_ptr got v=%b idx=%0d want v=1 idx=3", grant_valid, grant_idx);
    else pass_cnt++;
  endtask

  task automatic test_rotation();
    logic [7:0] exp_oh;
    do_reset();
    applyStimulus(8'hFF, 1'b0);
    for (int k = 0; k < 9; k++) begin
      exp_oh = 8'b1 << (k % 8);
      tick();
      check_cnt++;
      if ({grant_valid, grant_idx} !== {1'b1, 3'(k % 8)})
        $display("[TB] FAIL rot_grant%0d got v=%b idx=%0d want v=1 idx=%0d", k, grant_valid, grant_idx, k % 8);
      else pass_cnt++;
      check_cnt++;
      if (grant_onehot !== exp_oh)
        $display("[TB] FAIL rot_onehot%0d got %h want %h", k, grant_onehot, exp_oh);
      else pass_cnt++;
      tick();
      check_cnt++;
      if (grant_valid !== 1'b1 || !$onehot(grant_onehot))
        $display("[TB] FAIL rot_hold%0d got v=%b oh=%h want v=1 single-hot", k, grant_valid, grant_onehot);
      else pass_cnt++;
      applyStimulus(8'hFF, 1'b1);
      tick();
      check_cnt++;
      if ({grant_valid, timeout, grant_onehot} !== {1'b0, 1'b0, 8'h00})
        $display("[TB] FAIL rot_gap%0d got v=%b to=%b oh=%h want 0 0 00", k, grant_valid, timeout, grant_onehot);
      else pass_cnt++;
      applyStimulus(8'hFF, 1'b0);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    applyStimulus(8'h20, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      check_cnt++;
      if ({grant_valid, grant_idx, timeout} !== {1'b1, 3'd5, 1'b0})
        $display("[TB] FAIL to_hold%0d got v=%b idx=%0d to=%b want 1 5 0", c, grant_valid, grant_idx, timeout);
      else pass_cnt++;
    end
    tick();
    check_cnt++;
    if ({grant_valid, timeout} !== {1'b0, 1'b1})
      $display("[TB] FAIL to_pulse got v=%b to=%b want v=0 to=1", grant_valid, timeout);
    else pass_cnt++;
    tick();
    check_cnt++;
    if ({grant_valid, grant_idx, timeout} !== {1'b1, 3'd5, 1'b0})
      $display("[TB] FAIL to_regrant got v=%b idx=%0d to=%b want 1 5 0", grant_valid, grant_idx, timeout);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    do_reset();
    applyStimulus(8'h40, 1'b0);
    tick();
    applyStimulus(8'h40, 1'b1);
    tick();
    applyStimulus(8'b1000_0001, 1'b0);
    tick();
    check_cnt++;
    if ({grant_valid, grant_idx} !== {1'b1, 3'd7})
      $display("[TB] FAIL wrap_7 got v=%b idx=%0d want v=1 idx=7", grant_valid, grant_idx);
    else pass_cnt++;
    applyStimulus(8'b1000_0001, 1'b1);
    tick();
    applyStimulus(8'b1000_0001, 1'b0);
    tick();
    check_cnt++;
    if ({grant_valid, grant_idx, grant_onehot} !== {1'b1, 3'd0, 8'h01})
      $display("[TB] FAIL wrap_0 got v=%b idx=%0d oh=%h want 1 0 01", grant_valid, grant_idx, grant_onehot);
    else pass_cnt++;
  endtask

  task automatic test_release_causes();
    do_reset();
    applyStimulus(8'h08, 1'b0);
    tick();
    tick();
    applyStimulus(8'h00, 1'b0);
    tick();
    check_cnt++;
    if ({grant_valid, timeout} !== {1'b0, 1'b0})
      $display("[TB] FAIL withdraw got v=%b to=%b want 0 0", grant_valid, timeout);
    else pass_cnt++;
    // done lands on the same cycle the counter reaches MAX_HOLD
    do_reset();
    applyStimulus(8'h08, 1'b0);
    for (int c = 0; c < 4; c++) tick();
    applyStimulus(8'h08, 1'b1);
    tick();
    check_cnt++;
    if ({grant_valid, timeout} !== {1'b0, 1'b0})
      $display("[TB] FAIL done_vs_expiry got v=%b to=%b want 0 0", grant_valid, timeout);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    applyStimulus(8'h04, 1'b0);
    tick();
    applyStimulus(8'h04, 1'b1);
    tick();
    applyStimulus(8'h10, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_cnt++;
    if ({grant_valid, grant_idx, grant_onehot, timeout} !== {1'b0, 3'd0, 8'h00, 1'b0})
      $display("[TB] FAIL rst_mid got v=%b idx=%0d oh=%h to=%b want 0 0 00 0", grant_valid, grant_idx, grant_onehot, timeout);
    else pass_cnt++;
    // ptr was 3 before reset; picking 0 over 7 shows it returned to 0
    applyStimulus(8'b1000_0001, 1'b0);
    tick();
    check_cnt++;
    if ({grant_valid, grant_idx} !== {1'b1, 3'd0})
      $display("[TB] FAIL rst_ptr got v=%b idx=%0d want v=1 idx=0", grant_valid, grant_idx);
    else pass_cnt++;
    applyStimulus(8'h80, 1'b0);
    tick();
    tick();
    check_cnt++;
    if ({grant_valid, grant_idx, grant_onehot} !== {1'b1, 3'd7, 8'h80})
      $display("[TB] FAIL rst_req80 got v=%b idx=%0d oh=%h want 1 7 80", grant_valid, grant_idx, grant_onehot);
    else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1;
    req   = 8'h00;
    done  = 1'b0;
    test_reset();
    test_basic();
    test_rotation();
    test_timeout();
    test_wrap();
    test_release_causes();
    test_reset_mid_grant();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
